// File: rtl/fifo_sync_fwft_if.sv
// Bus bundle for the FWFT read adapter: FIFO-side strobe read plus the valid/ready stream.
// o_beats exists only when FIFO_FWFT_BEAT_COUNT_EN is defined.
interface fifo_sync_fwft_if #(parameter int DATA_WIDTH = 32);
   logic                  o_fifo_rd;
   logic [DATA_WIDTH-1:0] i_fifo_data;
   logic                  i_fifo_empty;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_valid;
   logic                  i_ready;
   logic [1:0]            o_count;
`ifdef FIFO_FWFT_BEAT_COUNT_EN
   logic [31:0]           o_beats;
`endif

   modport master (
      output o_fifo_rd,
      input  i_fifo_data,
      input  i_fifo_empty,
      output o_data,
      output o_valid,
      input  i_ready,
`ifdef FIFO_FWFT_BEAT_COUNT_EN
      output o_beats,
`endif
      output o_count
   );

   modport slave (
      input  o_fifo_rd,
      output i_fifo_data,
      output i_fifo_empty,
      input  o_data,
      input  o_valid,
      output i_ready,
`ifdef FIFO_FWFT_BEAT_COUNT_EN
      input  o_beats,
`endif
      input  o_count
   );
endinterface

// File: rtl/fifo_sync_fwft.sv
// First-word-fall-through adapter behind a 1-cycle-latency strobe-read FIFO.
// Optional beat counter enabled by defining FIFO_FWFT_BEAT_COUNT_EN.
module fifo_sync_fwft #(
   parameter int DATA_WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   fifo_sync_fwft_if.master bus
);

   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic                  valid;
   logic                  pop;
   logic                  head_free;
   logic [2:0]            credit;

   assign valid = (occ_q != 2'd0);
   assign pop   = valid && bus.i_ready;

   // Words held plus the one already requested, after this cycle's pop.
   assign credit     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign inflight_d = i_rstn && !bus.i_fifo_empty && (credit < 3'd2);
   assign occ_d      = credit[1:0];
   assign head_free  = (occ_q == 2'd0) || ((occ_q == 2'd1) && pop);

   always_comb begin
      head_d = head_q;
      skid_d = skid_q;
      if (pop && (occ_q == 2'd2))
         head_d = skid_q;
      if (inflight_q) begin
         if (head_free)
            head_d = bus.i_fifo_data;
         else
            skid_d = bus.i_fifo_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         head_q     <= '0;
         skid_q     <= '0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         skid_q     <= skid_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
      end
   end

   assign bus.o_fifo_rd = inflight_d;
   assign bus.o_valid   = valid;
   assign bus.o_data    = head_q;
   assign bus.o_count   = occ_q;

`ifdef FIFO_FWFT_BEAT_COUNT_EN
   logic [31:0] beats_q, beats_d;

   assign beats_d = pop ? beats_q + 32'd1 : beats_q;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)
         beats_q <= 32'd0;
      else
         beats_q <= beats_d;
   end

   assign bus.o_beats = beats_q;
`endif

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Bench for fifo_sync_fwft: behavioural fifo_sync upstream, scoreboard monitor on the stream side.
module tb_fifo_sync_fwft;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fifo_sync_fwft_if #(.DATA_WIDTH(DW)) bus();

   fifo_sync_fwft #(.DATA_WIDTH(DW)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   int tests = 0;
   int fails = 0;
   int rd_cnt = 0;
   int pops_total = 0;
   logic [DW-1:0] expq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Upstream fifo_sync model: registered empty, read data one cycle after strobe.
   logic [DW-1:0] mem [0:63];
   int wp, rp, mcnt;
   logic wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic force_ne = 1'b0;
   logic ready = 1'b0;

   assign bus.i_fifo_empty = force_ne ? 1'b0 : (mcnt == 0);
   assign bus.i_ready = ready;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp <= 0; rp <= 0; mcnt <= 0;
         bus.i_fifo_data <= '0;
      end else begin
         if (wr_en) begin
            mem[wp % 64] <= wr_data;
            wp <= wp + 1;
         end
         if (bus.o_fifo_rd) begin
            bus.i_fifo_data <= mem[rp % 64];
            rp <= rp + 1;
         end
         mcnt <= mcnt + (wr_en ? 1 : 0) - (bus.o_fifo_rd ? 1 : 0);
      end
   end

   // Scoreboard monitor and invariants.
   always @(negedge clk) begin
      if (!rstn) begin
         pops_total = 0;
      end else begin
         if (bus.o_fifo_rd) rd_cnt++;
         chk("rd_while_empty", {31'd0, bus.o_fifo_rd && bus.i_fifo_empty}, 32'd0);
         chk("count_le_2", {31'd0, bus.o_count > 2'd2}, 32'd0);
         if (bus.o_valid && bus.i_ready) begin
            pops_total++;
            if (expq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_word: got %0h expected none", bus.o_data);
            end else begin
               chk("stream_data", bus.o_data, expq.pop_front());
            end
         end
      end
   end

   task automatic wr(input logic [DW-1:0] w);
      wr_en = 1'b1;
      wr_data = w;
      expq.push_back(w);
      @(posedge clk); #1;
   endtask

   task automatic wr_stop();
      wr_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int rd0, rd_idx, v_idx, v_n, run, maxrun, vcnt;
      bit found;
      logic [31:0] seq;

      // Reset with a non-empty FIFO presented.
      force_ne = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("rst_rd", {31'd0, bus.o_fifo_rd}, 32'd0);
         chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
         chk("rst_count", {30'd0, bus.o_count}, 32'd0);
      end
      chk("rst_data", bus.o_data, 32'd0);
`ifdef FIFO_FWFT_BEAT_COUNT_EN
      chk("rst_beats", bus.o_beats, 32'd0);
`endif
      @(posedge clk); #1;
      force_ne = 1'b0;
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_rd", {31'd0, bus.o_fifo_rd}, 32'd0);
      chk("post_rst_valid", {31'd0, bus.o_valid}, 32'd0);
      chk("post_rst_count", {30'd0, bus.o_count}, 32'd0);
      idle(1);

      // Single word: one strobe, valid two cycles later for one cycle.
      ready = 1'b1;
      rd_idx = -1; v_idx = -1; v_n = 0; rd0 = rd_cnt;
      fork
         begin wr(32'hA5A5_0001); wr_stop(); end
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_fifo_rd && rd_idx < 0) rd_idx = i;
            if (bus.o_valid) begin
               v_n++;
               if (v_idx < 0) v_idx = i;
               chk("single_data", bus.o_data, 32'hA5A5_0001);
            end
         end
      join
      chk("single_rd_pulses", rd_cnt - rd0, 32'd1);
      chk("single_latency", v_idx - rd_idx, 32'd2);
      chk("single_valid_cycles", v_n, 32'd1);
      idle(1);

      // Backpressure: 4 words queued, only 2 read, head held.
      ready = 1'b0;
      rd0 = rd_cnt;
      wr(32'd1); wr(32'd2); wr(32'd3); wr(32'd4); wr_stop();
      idle(6);
      @(negedge clk);
      chk("bp_rd_pulses", rd_cnt - rd0, 32'd2);
      chk("bp_count", {30'd0, bus.o_count}, 32'd2);
      chk("bp_data", bus.o_data, 32'd1);
      idle(3);
      @(negedge clk);
      chk("bp_data_stable", bus.o_data, 32'd1);
      chk("bp_valid_stable", {31'd0, bus.o_valid}, 32'd1);
      @(posedge clk); #1;
      ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("bp_drain_valid", {31'd0, bus.o_valid}, 32'd1);
         chk("bp_drain_data", bus.o_data, k);
      end
      idle(3);

      // Streaming: 16 back-to-back words, valid for 16 consecutive cycles.
      run = 0; maxrun = 0; vcnt = 0;
      fork
         begin
            for (int k = 0; k < 16; k++) wr(32'h100 + k);
            wr_stop();
         end
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_valid) begin
               vcnt++; run++;
               if (run > maxrun) maxrun = run;
            end else run = 0;
         end
      join
      chk("stream_run", maxrun, 32'd16);
      chk("stream_valid_total", vcnt, 32'd16);
      chk("stream_count_zero", {30'd0, bus.o_count}, 32'd0);

      // Random writes and random ready.
      seq = 32'h1000;
      for (int c = 0; c < 2000; c++) begin
         ready = 1'($urandom_range(0, 1));
         if (mcnt < 56 && $urandom_range(0, 1) == 1) begin
            wr(seq); seq++;
         end else begin
            wr_stop(); @(posedge clk); #1;
         end
      end
      wr_stop();
      ready = 1'b1;
      idle(80);
      chk("stress_drained", expq.size(), 32'd0);
`ifdef FIFO_FWFT_BEAT_COUNT_EN
      @(negedge clk);
      chk("stress_beats", bus.o_beats, pops_total);
`endif

      // Reset the cycle after a read strobe: in-flight word is dropped.
      ready = 1'b0;
      wr(32'hDEAD_0001); wr_stop();
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (bus.o_fifo_rd) found = 1'b1;
      end
      chk("mid_rd_seen", {31'd0, found}, 32'd1);
      @(posedge clk); #1;
      rstn = 1'b0;
      expq.delete();
      repeat (3) begin
         @(negedge clk);
         chk("mid_rst_valid", {31'd0, bus.o_valid}, 32'd0);
         chk("mid_rst_count", {30'd0, bus.o_count}, 32'd0);
         chk("mid_rst_rd", {31'd0, bus.o_fifo_rd}, 32'd0);
`ifdef FIFO_FWFT_BEAT_COUNT_EN
         chk("mid_rst_beats", bus.o_beats, 32'd0);
`endif
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      ready = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.o_valid) vcnt++;
      end
      chk("mid_no_stale", vcnt, 32'd0);
      @(posedge clk); #1;
      wr(32'h0000_0055); wr_stop();
      idle(6);
      chk("post_mid_drained", expq.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
